kbest_merger: RTL and testbench

//  Consumes the sorted top-K (distance, index) lists that the bitonic sorter emits, one list per

---
 rtl/kbest_merger_if.sv | 25 ++
 rtl/kbest_merger.sv | 155 +++++++++++++++
 tb/tb_kbest_merger.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/kbest_merger_if.sv
// Streaming port bundle for kbest_merger: one sorted K-entry (distance, index) list per beat
// in, one final K-best list plus leaf count out.
interface kbest_merger_if #(
    parameter int DIST_WIDTH = 25,
    parameter int IDX_WIDTH  = 15,
    parameter int K          = 4
);
    logic                  valid_in;
    logic                  last_in;
    logic [DIST_WIDTH-1:0] data_in  [K];
    logic [IDX_WIDTH-1:0]  idx_in   [K];
    logic                  valid_out;
    logic [DIST_WIDTH-1:0] data_out [K];
    logic [IDX_WIDTH-1:0]  idx_out  [K];
    logic [7:0]            leaves_out;

    modport master (
        output valid_in, last_in, data_in, idx_in,
        input  valid_out, data_out, idx_out, leaves_out
    );
    modport slave (
        input  valid_in, last_in, data_in, idx_in,
        output valid_out, data_out, idx_out, leaves_out
    );
endinterface

// File: rtl/kbest_merger.sv
// Running best-K merger of per-leaf sorted lists for one query; emits the final K on last_in.
// Optional feature macro: KBEST_DEDUP_EN (drop incoming entries whose idx is already running).
module kbest_merger #(
    parameter int DIST_WIDTH = 25,
    parameter int IDX_WIDTH  = 15,
    parameter int K          = 4
) (
    input  logic           clk,
    input  logic           rst,
    kbest_merger_if.slave  bus
);
    typedef enum logic {EMPTY, ACCUM} state_t;

    state_t                state_reg, state_next;
    logic [7:0]            count_reg, count_inc;
    logic [DIST_WIDTH-1:0] run_d_reg [K];
    logic [IDX_WIDTH-1:0]  run_i_reg [K];
    logic [DIST_WIDTH-1:0] inc_d [K];
    logic [IDX_WIDTH-1:0]  inc_i [K];
    logic [2:0]            rank_a [K];
    logic [2:0]            rank_b [K];
    logic [DIST_WIDTH-1:0] mrg_d [K];
    logic [IDX_WIDTH-1:0]  mrg_i [K];
    logic [DIST_WIDTH-1:0] nxt_d [K];
    logic [IDX_WIDTH-1:0]  nxt_i [K];
    logic                  valid_out_reg;
    logic [DIST_WIDTH-1:0] out_d_reg [K];
    logic [IDX_WIDTH-1:0]  out_i_reg [K];
    logic [7:0]            leaves_reg;

`ifdef KBEST_DEDUP_EN
    logic [K-1:0] keep;
    logic [2:0]   slot;

    always_comb begin
        for (int j = 0; j < K; j++) begin
            keep[j] = 1'b1;
            for (int i = 0; i < K; i++)
                if (bus.idx_in[j] == run_i_reg[i]) keep[j] = 1'b0;
        end
    end

    // Compact surviving entries to the front so the incoming list stays sorted; pad with max.
    always_comb begin
        for (int s = 0; s < K; s++) begin
            inc_d[s] = '1;
            inc_i[s] = '0;
        end
        slot = 3'd0;
        for (int j = 0; j < K; j++) begin
            if (keep[j]) begin
                inc_d[slot[1:0]] = bus.data_in[j];
                inc_i[slot[1:0]] = bus.idx_in[j];
                slot = slot + 3'd1;
            end
        end
    end
`else
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_pass
            assign inc_d[gi] = bus.data_in[gi];
            assign inc_i[gi] = bus.idx_in[gi];
        end
    endgenerate
`endif

    // Cross-rank merge: an entry's output slot is its own position plus the number of entries of
    // the other list ahead of it. Strict < for incoming vs <= for running puts running first on ties.
    genvar gr;
    generate
        for (gr = 0; gr < K; gr++) begin : g_rank
            assign rank_a[gr] = 3'(gr)
                              + 3'(inc_d[0] < run_d_reg[gr]) + 3'(inc_d[1] < run_d_reg[gr])
                              + 3'(inc_d[2] < run_d_reg[gr]) + 3'(inc_d[3] < run_d_reg[gr]);
            assign rank_b[gr] = 3'(gr)
                              + 3'(run_d_reg[0] <= inc_d[gr]) + 3'(run_d_reg[1] <= inc_d[gr])
                              + 3'(run_d_reg[2] <= inc_d[gr]) + 3'(run_d_reg[3] <= inc_d[gr]);
        end
    endgenerate

    // Unsorted inputs can collide ranks; zero defaults keep the result defined.
    always_comb begin
        for (int s = 0; s < K; s++) begin
            mrg_d[s] = '0;
            mrg_i[s] = '0;
            for (int i = 0; i < K; i++)
                if (rank_a[i] == 3'(s)) begin
                    mrg_d[s] = run_d_reg[i];
                    mrg_i[s] = run_i_reg[i];
                end
            for (int j = 0; j < K; j++)
                if (rank_b[j] == 3'(s)) begin
                    mrg_d[s] = inc_d[j];
                    mrg_i[s] = inc_i[j];
                end
        end
    end

    always_comb begin
        state_next = state_reg;
        count_inc  = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
        for (int s = 0; s < K; s++) begin
            nxt_d[s] = (state_reg == EMPTY) ? bus.data_in[s] : mrg_d[s];
            nxt_i[s] = (state_reg == EMPTY) ? bus.idx_in[s]  : mrg_i[s];
        end
        if (bus.valid_in)
            state_next = bus.last_in ? EMPTY : ACCUM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            count_reg     <= 8'd0;
            valid_out_reg <= 1'b0;
            leaves_reg    <= 8'd0;
            for (int s = 0; s < K; s++) begin
                run_d_reg[s] <= '0;
                run_i_reg[s] <= '0;
                out_d_reg[s] <= '0;
                out_i_reg[s] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            valid_out_reg <= 1'b0;
            if (bus.valid_in) begin
                if (bus.last_in) begin
                    valid_out_reg <= 1'b1;
                    leaves_reg    <= count_inc;
                    count_reg     <= 8'd0;
                    for (int s = 0; s < K; s++) begin
                        out_d_reg[s] <= nxt_d[s];
                        out_i_reg[s] <= nxt_i[s];
                    end
                end else begin
                    count_reg <= count_inc;
                    for (int s = 0; s < K; s++) begin
                        run_d_reg[s] <= nxt_d[s];
                        run_i_reg[s] <= nxt_i[s];
                    end
                end
            end
        end
    end

    assign bus.valid_out  = valid_out_reg;
    assign bus.leaves_out = leaves_reg;
    genvar go;
    generate
        for (go = 0; go < K; go++) begin : g_out
            assign bus.data_out[go] = out_d_reg[go];
            assign bus.idx_out[go]  = out_i_reg[go];
        end
    endgenerate
endmodule

// File: tb/tb_kbest_merger.sv
// Self-checking bench for kbest_merger: directed cases then randomized beats against a
// stable-sort reference model of the running best-K list.
module tb_kbest_merger;
    localparam int DW = 25;
    localparam int IW = 15;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kbest_merger_if #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(4)) bus ();
    kbest_merger #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] sd [4];
    logic [IW-1:0] si [4];

    // reference model state
    ent_t          run_q [$];
    int            m_count = 0;
    logic          e_valid = 1'b0;
    logic [DW-1:0] e_d [4] = '{default: '0};
    logic [IW-1:0] e_i [4] = '{default: '0};
    logic [7:0]    e_leaves = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input bit r, input bit v, input bit l);
        ent_t inc [$];
        ent_t all [$];
        ent_t tmp;
        bit   dup;
        e_valid = 1'b0;
        if (r) begin
            run_q.delete();
            m_count  = 0;
            e_leaves = 8'd0;
            for (int k = 0; k < 4; k++) begin e_d[k] = '0; e_i[k] = '0; end
            return;
        end
        if (!v) return;
        for (int k = 0; k < 4; k++) begin
            tmp.d = sd[k];
            tmp.i = si[k];
            dup = 1'b0;
`ifdef KBEST_DEDUP_EN
            foreach (run_q[q]) if (run_q[q].i == si[k]) dup = 1'b1;
`endif
            if (!dup || run_q.size() == 0) inc.push_back(tmp);
        end
        while (inc.size() < 4) begin tmp.d = '1; tmp.i = '0; inc.push_back(tmp); end
        all = run_q;
        foreach (inc[k]) all.push_back(inc[k]);
        // stable insertion sort: earlier (running) entries win ties
        for (int a = 1; a < all.size(); a++)
            for (int b = a; b > 0 && all[b-1].d > all[b].d; b--) begin
                tmp = all[b]; all[b] = all[b-1]; all[b-1] = tmp;
            end
        m_count = (m_count < 255) ? m_count + 1 : 255;
        if (l) begin
            e_valid  = 1'b1;
            e_leaves = 8'(m_count);
            for (int k = 0; k < 4; k++) begin e_d[k] = all[k].d; e_i[k] = all[k].i; end
            run_q.delete();
            m_count = 0;
        end else begin
            run_q.delete();
            for (int k = 0; k < 4; k++) run_q.push_back(all[k]);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit l);
        @(negedge clk);
        rst          = r;
        bus.valid_in = v;
        bus.last_in  = l;
        for (int k = 0; k < 4; k++) begin bus.data_in[k] = sd[k]; bus.idx_in[k] = si[k]; end
        @(posedge clk);
        #1;
        model_beat(r, v, l);
        chk("valid_out", 32'(bus.valid_out), 32'(e_valid));
        chk("leaves_out", 32'(bus.leaves_out), 32'(e_leaves));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("data_out_%0d", k), 32'(bus.data_out[k]), 32'(e_d[k]));
            chk($sformatf("idx_out_%0d", k), 32'(bus.idx_out[k]), 32'(e_i[k]));
        end
        $display("t=%0t rst=%0b v=%0b l=%0b d_in=%0d,%0d,%0d,%0d -> vo=%0b lv=%0d d_out=%0d,%0d,%0d,%0d",
                 $time, r, v, l, sd[0], sd[1], sd[2], sd[3], bus.valid_out, bus.leaves_out,
                 bus.data_out[0], bus.data_out[1], bus.data_out[2], bus.data_out[3]);
    endtask

    task automatic set_list(input int d0, d1, d2, d3, input int i0, i1, i2, i3);
        sd[0] = DW'(d0); sd[1] = DW'(d1); sd[2] = DW'(d2); sd[3] = DW'(d3);
        si[0] = IW'(i0); si[1] = IW'(i1); si[2] = IW'(i2); si[3] = IW'(i3);
    endtask

    // absolute check against literal expectations, independent of the model
    task automatic expect_out(input string tag, input int d0, d1, d2, d3,
                              input int i0, i1, i2, i3, input int lv);
        int ed [4];
        int ei [4];
        ed = '{d0, d1, d2, d3};
        ei = '{i0, i1, i2, i3};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_d%0d", tag, k), 32'(bus.data_out[k]), 32'(ed[k]));
            chk($sformatf("%s_i%0d", tag, k), 32'(bus.idx_out[k]), 32'(ei[k]));
        end
        chk({tag, "_leaves"}, 32'(bus.leaves_out), 32'(lv));
        chk({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    endtask

    task automatic rand_list();
        int v [4];
        int t;
        for (int k = 0; k < 4; k++) v[k] = int'($urandom_range(0, 15));
        for (int a = 1; a < 4; a++)
            for (int b = a; b > 0 && v[b-1] > v[b]; b--) begin
                t = v[b]; v[b] = v[b-1]; v[b-1] = t;
            end
        for (int k = 0; k < 4; k++) begin
            sd[k] = DW'(v[k]);
            si[k] = IW'($urandom_range(0, 9));
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        set_list(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        // 1: single list
        set_list(0, 3, 20, 83, 0, 1, 2, 3);
        step(0, 1, 1);
        expect_out("t1", 0, 3, 20, 83, 0, 1, 2, 3, 1);
        step(0, 0, 0);
        chk("t1_pulse", 32'(bus.valid_out), 32'd0);

        // 2: two lists
        set_list(0, 3, 20, 83, 0, 1, 2, 3);   step(0, 1, 0);
        set_list(1, 2, 2, 11, 64, 65, 66, 67); step(0, 1, 1);
        expect_out("t2", 0, 1, 2, 2, 0, 64, 65, 66, 2);

        // 3: tie rule
        set_list(5, 6, 7, 8, 1, 2, 3, 4);      step(0, 1, 0);
        set_list(5, 5, 9, 9, 9, 10, 11, 12);   step(0, 1, 1);
        expect_out("t3", 5, 5, 5, 6, 1, 9, 10, 2, 2);

        // 4: back-to-back queries
        set_list(1, 2, 3, 4, 10, 11, 12, 13);  step(0, 1, 1);
        expect_out("t4a", 1, 2, 3, 4, 10, 11, 12, 13, 1);
        set_list(7, 8, 9, 10, 20, 21, 22, 23); step(0, 1, 1);
        expect_out("t4b", 7, 8, 9, 10, 20, 21, 22, 23, 1);

        // 5: reset mid-query; last_in without valid_in is ignored
        set_list(0, 3, 20, 83, 0, 1, 2, 3);    step(0, 1, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        set_list(1, 2, 2, 11, 64, 65, 66, 67); step(0, 1, 1);
        expect_out("t5", 1, 2, 2, 11, 64, 65, 66, 67, 1);

        // 6: duplicate indices
        set_list(0, 3, 20, 83, 0, 1, 2, 3);    step(0, 1, 0);
        set_list(3, 4, 25, 30, 1, 64, 65, 66); step(0, 1, 1);
`ifdef KBEST_DEDUP_EN
        expect_out("t6", 0, 3, 4, 20, 0, 1, 64, 2, 2);
`else
        expect_out("t6", 0, 3, 3, 4, 0, 1, 1, 64, 2);
`endif

        // count saturation at 255, valid_in every cycle
        for (int n = 0; n < 259; n++) begin
            set_list(n % 7, 50, 60, 70, n % 5, 1, 2, 3);
            step(0, 1, (n == 258));
        end
        chk("sat_leaves", 32'(bus.leaves_out), 32'd255);

        // randomized beats
        for (int n = 0; n < 400; n++) begin
            bit v, l, r;
            rand_list();
            r = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 2) == 0);
            step(r, v, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
